mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing Core101's single external memory bus between the instruction-fetch path and the data-memory path of the datapath. Accepts one request at a time over valid/ready, drives a registered single-outstanding bus transaction, and returns a one-cycle response pulse to the originating requester. Data accesses have priority, with a starvation guard for fetch and an optional bus timeout. Sits between DATAPATH and the top-level memory pins.

## Interface
- ADDR_WIDTH, 32, address width of requests and bus.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits.
- MAX_WAIT, 15, bus cycles without ack before timeout (only with MEM_ARBITER_TIMEOUT_EN).

Ports:
- mem_arbiter_clock_in  in  1  single clock; all state on rising edge.
- mem_arbiter_reset_in  in  1  synchronous, active-low reset.
- if_req_valid_in  in  1  fetch request.
- if_req_ready_out  out  1  fetch request accepted this cycle.
- if_addr_in  in  ADDR_WIDTH  fetch address.
- if_rsp_valid_out  out  1  one-cycle fetch response pulse.
- if_rsp_data_out  out  DATA_WIDTH  fetched word.
- if_rsp_err_out  out  1  fetch timed out.
- dm_req_valid_in  in  1  data request.
- dm_req_ready_out  out  1  data request accepted.
- dm_addr_in  in  ADDR_WIDTH  data address.
- dm_we_in  in  1  1 = write.
- dm_wstrb_in  in  DATA_WIDTH/8  byte enables for writes.
- dm_wdata_in  in  DATA_WIDTH  write data.
- dm_rsp_valid_out  out  1  one-cycle data response pulse.
- dm_rsp_data_out  out  DATA_WIDTH  read data (0 for writes).
- dm_rsp_err_out  out  1  data access timed out.
- bus_req_out  out  1  bus transaction active.
- bus_addr_out  out  ADDR_WIDTH  bus address.
- bus_we_out  out  1  bus write.
- bus_wstrb_out  out  DATA_WIDTH/8  bus byte enables (0 on reads).
- bus_wdata_out  out  DATA_WIDTH  bus write data.
- bus_rdata_in  in  DATA_WIDTH  bus read data, valid with ack.
- bus_ack_in  in  1  transaction complete.

## Operation
- States: IDLE, BUS_IF, BUS_DM.
- IDLE: winner = dm if dm_req_valid_in and starve_cnt < STARVE_LIMIT; else if if_req_valid_in; else dm if dm_req_valid_in. Ready is combinational, asserted only to the winner, only in IDLE, only with reset high.
- Accept (valid & ready): latch addr/we/wstrb/wdata into bus registers, go to BUS_IF/BUS_DM. Fetch forces we=0, wstrb=0.
- starve_cnt: increments on dm grant while if_req_valid_in high (saturates at STARVE_LIMIT); clears on fetch grant or whenever if_req_valid_in low in IDLE.
- BUS_x: bus outputs held stable until bus_ack_in. On ack: capture bus_rdata_in (zeroed for writes), pulse matching rsp_valid next cycle, err=0, return to IDLE.
- bus_ack_in in IDLE is ignored.
- Reset (any state): state IDLE, starve_cnt 0, all outputs 0; in-flight transaction dropped, no response issued.

## Timing
- Accept at cycle N → bus_req_out high N+1 → earliest ack N+1 → rsp_valid N+2; IDLE again at N+2, next accept possible at N+2 (2-cycle throughput).
- rsp_valid is exactly one cycle; rsp_data/err hold until next response.
- All outputs except the two ready signals are registered.

## Configuration
- MEM_ARBITER_TIMEOUT_EN defined: wait counter clears on accept, increments each BUS_x cycle without ack; when it reaches MAX_WAIT, bus_req_out drops, response pulses with err=1, data 0, state returns to IDLE. Ack in the same cycle as the limit is reached wins (normal response).
- Undefined: no counter; waits indefinitely; both err outputs tied 0.

## Structure
- core101_pkg: state encoding constants (IDLE/BUS_IF/BUS_DM), default widths, STARVE_LIMIT/MAX_WAIT defaults.
- Sub-module mem_arbiter_timer: the timeout counter, instantiated only under MEM_ARBITER_TIMEOUT_EN.

## Test plan
- Fetch 0x100, ack same cycle as bus_req with rdata 0xDEADBEEF → if_rsp_valid 2 cycles after accept, data 0xDEADBEEF, err 0.
- Both valid continuously, ack immediate → grants D,D,D,D,I,D,…; fetch granted after exactly 4 data grants.
- Data write addr 0x2000, wstrb 0x3, wdata 0x1234, ack after 3 wait cycles → bus fields stable for 4 cycles; dm_rsp data 0.
- Timeout enabled, never ack → bus_req high 15 cycles, then dm_rsp_valid with err 1; ack on 15th cycle → err 0.
- Reset low while BUS_IF waiting, then ack → no rsp_valid, bus_req 0, next fetch accepted normally.

Source files
------------

// File: rtl/core101_pkg.sv
// Shared types and defaults for the Core101 memory arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package core101_pkg;

    // Default widths and arbitration limits.
    localparam int CORE101_ADDR_WIDTH   = 32;
    localparam int CORE101_DATA_WIDTH   = 32;
    localparam int CORE101_STARVE_LIMIT = 4;
    localparam int CORE101_MAX_WAIT     = 15;

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS_IF = 2'd1,
        ST_BUS_DM = 2'd2
    } arb_state_e;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Bus wait counter: flags expiry when a transaction has gone MAX_WAIT cycles without ack.
// Latency: expire_o is combinational from the registered count and the current ack.
// Backpressure: none; an ack in the final cycle suppresses expiry.
module mem_arbiter_timer
    import core101_pkg::*;
#(
    parameter int MAX_WAIT = CORE101_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int            CW   = cnt_width(MAX_WAIT);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count bus cycles without ack; restart on every accepted request.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (busy_i && !ack_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The cycle that would be the MAX_WAIT-th unacked one ends the transaction.
    assign expire_o = busy_i && !ack_i && (cnt_q == LAST);

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single external memory bus; optional timeout via MEM_ARBITER_TIMEOUT_EN.
// Latency: accept at N, bus request N+1, response pulse one cycle after ack (earliest N+2).
// Backpressure: ready only in IDLE and only to the winner; one transaction outstanding.
module mem_arbiter
    import core101_pkg::*;
#(
    parameter int ADDR_WIDTH   = CORE101_ADDR_WIDTH,
    parameter int DATA_WIDTH   = CORE101_DATA_WIDTH,
    parameter int STARVE_LIMIT = CORE101_STARVE_LIMIT,
    parameter int MAX_WAIT     = CORE101_MAX_WAIT
) (
    input  logic                    mem_arbiter_clock_in,
    input  logic                    mem_arbiter_reset_in,
    input  logic                    if_req_valid_in,
    output logic                    if_req_ready_out,
    input  logic [ADDR_WIDTH-1:0]   if_addr_in,
    output logic                    if_rsp_valid_out,
    output logic [DATA_WIDTH-1:0]   if_rsp_data_out,
    output logic                    if_rsp_err_out,
    input  logic                    dm_req_valid_in,
    output logic                    dm_req_ready_out,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_in,
    input  logic                    dm_we_in,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb_in,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_in,
    output logic                    dm_rsp_valid_out,
    output logic [DATA_WIDTH-1:0]   dm_rsp_data_out,
    output logic                    dm_rsp_err_out,
    output logic                    bus_req_out,
    output logic [ADDR_WIDTH-1:0]   bus_addr_out,
    output logic                    bus_we_out,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb_out,
    output logic [DATA_WIDTH-1:0]   bus_wdata_out,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_in,
    input  logic                    bus_ack_in
);

    localparam int            SW         = cnt_width(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam int            SBW        = DATA_WIDTH / 8;

    if (STARVE_LIMIT < 1 || MAX_WAIT < 1) begin : g_param_check
        $error("mem_arbiter: STARVE_LIMIT and MAX_WAIT must be at least 1");
    end

    arb_state_e            state_q, state_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  bus_req_q, bus_req_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic                  bus_we_q, bus_we_d;
    logic [SBW-1:0]        bus_wstrb_q, bus_wstrb_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  if_rsp_vld_q, if_rsp_vld_d;
    logic                  dm_rsp_vld_q, dm_rsp_vld_d;
    logic [DATA_WIDTH-1:0] if_rsp_dat_q, if_rsp_dat_d;
    logic [DATA_WIDTH-1:0] dm_rsp_dat_q, dm_rsp_dat_d;

    logic                  idle;
    logic                  busy;
    logic                  grant_dm;
    logic                  grant_if;
    logic                  accept;
    logic                  timeout;
    logic                  bus_done;
    logic [DATA_WIDTH-1:0] rsp_dat;

    // Data wins unless it has used up its quota while fetch waits; fetch next; data as fallback.
    assign idle     = (state_q == ST_IDLE) && mem_arbiter_reset_in;
    assign busy     = (state_q != ST_IDLE);
    assign grant_dm = idle && dm_req_valid_in && ((starve_q < STARVE_MAX) || !if_req_valid_in);
    assign grant_if = idle && if_req_valid_in && !grant_dm;
    assign accept   = grant_dm || grant_if;

    assign if_req_ready_out = grant_if;
    assign dm_req_ready_out = grant_dm;

    // A transaction ends on ack, or on timeout when ack does not arrive in time.
    assign bus_done = busy && (bus_ack_in || timeout);
    assign rsp_dat  = (bus_ack_in && !bus_we_q) ? bus_rdata_in : '0;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic if_err_q, if_err_d;
    logic dm_err_q, dm_err_d;

    mem_arbiter_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk_i    (mem_arbiter_clock_in),
        .rst_ni   (mem_arbiter_reset_in),
        .start_i  (accept),
        .busy_i   (busy),
        .ack_i    (bus_ack_in),
        .expire_o (timeout)
    );

    // Error flag follows the response it belongs to; ack beats a simultaneous expiry.
    always_comb begin
        if_err_d = if_err_q;
        dm_err_d = dm_err_q;
        if (bus_done) begin
            if (state_q == ST_BUS_IF) begin
                if_err_d = !bus_ack_in;
            end else begin
                dm_err_d = !bus_ack_in;
            end
        end
    end

    // Error flag registers.
    always_ff @(posedge mem_arbiter_clock_in) begin
        if (!mem_arbiter_reset_in) begin
            if_err_q <= 1'b0;
            dm_err_q <= 1'b0;
        end else begin
            if_err_q <= if_err_d;
            dm_err_q <= dm_err_d;
        end
    end

    assign if_rsp_err_out = if_err_q;
    assign dm_rsp_err_out = dm_err_q;
`else
    assign timeout        = 1'b0;
    assign if_rsp_err_out = 1'b0;
    assign dm_rsp_err_out = 1'b0;
`endif

    // Next-state: arbitration and bus launch in IDLE, completion tracking in the bus states.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        bus_req_d    = bus_req_q;
        bus_addr_d   = bus_addr_q;
        bus_we_d     = bus_we_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_wdata_d  = bus_wdata_q;
        if_rsp_vld_d = 1'b0;
        dm_rsp_vld_d = 1'b0;
        if_rsp_dat_d = if_rsp_dat_q;
        dm_rsp_dat_d = dm_rsp_dat_q;

        case (state_q)
            ST_IDLE: begin
                // Starvation history only counts while fetch is continuously asking.
                if (!if_req_valid_in) begin
                    starve_d = '0;
                end
                if (grant_dm) begin
                    state_d     = ST_BUS_DM;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = dm_addr_in;
                    bus_we_d    = dm_we_in;
                    bus_wstrb_d = dm_we_in ? dm_wstrb_in : '0;
                    bus_wdata_d = dm_wdata_in;
                    if (if_req_valid_in && (starve_q < STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (grant_if) begin
                    state_d     = ST_BUS_IF;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = if_addr_in;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = '0;
                    bus_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            ST_BUS_IF, ST_BUS_DM: begin
                if (bus_done) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == ST_BUS_IF) begin
                        if_rsp_vld_d = 1'b1;
                        if_rsp_dat_d = rsp_dat;
                    end else begin
                        dm_rsp_vld_d = 1'b1;
                        dm_rsp_dat_d = rsp_dat;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction silently.
    always_ff @(posedge mem_arbiter_clock_in) begin
        if (!mem_arbiter_reset_in) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= '0;
            bus_we_q     <= 1'b0;
            bus_wstrb_q  <= '0;
            bus_wdata_q  <= '0;
            if_rsp_vld_q <= 1'b0;
            dm_rsp_vld_q <= 1'b0;
            if_rsp_dat_q <= '0;
            dm_rsp_dat_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            bus_req_q    <= bus_req_d;
            bus_addr_q   <= bus_addr_d;
            bus_we_q     <= bus_we_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rsp_vld_q <= if_rsp_vld_d;
            dm_rsp_vld_q <= dm_rsp_vld_d;
            if_rsp_dat_q <= if_rsp_dat_d;
            dm_rsp_dat_q <= dm_rsp_dat_d;
        end
    end

    assign bus_req_out      = bus_req_q;
    assign bus_addr_out     = bus_addr_q;
    assign bus_we_out       = bus_we_q;
    assign bus_wstrb_out    = bus_wstrb_q;
    assign bus_wdata_out    = bus_wdata_q;
    assign if_rsp_valid_out = if_rsp_vld_q;
    assign if_rsp_data_out  = if_rsp_dat_q;
    assign dm_rsp_valid_out = dm_rsp_vld_q;
    assign dm_rsp_data_out  = dm_rsp_dat_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven transactions, corner sequences, random vs model.
// Latency: inputs driven and outputs sampled at the falling clock edge.
// Backpressure: requesters hold valid and payload until ready is seen.
module tb_mem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int STARVE = 4;
    localparam int MAXW   = 15;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_v, if_rdy, if_rsp_v, if_rsp_err;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rsp_dat;
    logic          dm_v, dm_rdy, dm_we, dm_rsp_v, dm_rsp_err;
    logic [AW-1:0] dm_addr;
    logic [3:0]    dm_wstrb;
    logic [DW-1:0] dm_wdata, dm_rsp_dat;
    logic          bus_req, bus_we, bus_ack;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_wstrb;
    logic [DW-1:0] bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(STARVE), .MAX_WAIT(MAXW)
    ) dut (
        .mem_arbiter_clock_in(clk),      .mem_arbiter_reset_in(rst_n),
        .if_req_valid_in(if_v),          .if_req_ready_out(if_rdy),
        .if_addr_in(if_addr),            .if_rsp_valid_out(if_rsp_v),
        .if_rsp_data_out(if_rsp_dat),    .if_rsp_err_out(if_rsp_err),
        .dm_req_valid_in(dm_v),          .dm_req_ready_out(dm_rdy),
        .dm_addr_in(dm_addr),            .dm_we_in(dm_we),
        .dm_wstrb_in(dm_wstrb),          .dm_wdata_in(dm_wdata),
        .dm_rsp_valid_out(dm_rsp_v),     .dm_rsp_data_out(dm_rsp_dat),
        .dm_rsp_err_out(dm_rsp_err),     .bus_req_out(bus_req),
        .bus_addr_out(bus_addr),         .bus_we_out(bus_we),
        .bus_wstrb_out(bus_wstrb),       .bus_wdata_out(bus_wdata),
        .bus_rdata_in(bus_rdata),        .bus_ack_in(bus_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_v = 1'b0; if_addr = '0;
        dm_v = 1'b0; dm_addr = '0; dm_we = 1'b0; dm_wstrb = '0; dm_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
    endtask

    // Two reset cycles with both requesters asking; nothing may be granted, outputs all zero.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0; if_v = 1'b1; dm_v = 1'b1;
        #1;
        chk("rst_if_ready", if_rdy, 0);
        chk("rst_dm_ready", dm_rdy, 0);
        @(negedge clk);
        #1;
        chk("rst_if_ready2", if_rdy, 0);
        chk("rst_dm_ready2", dm_rdy, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_rsp_valid", {if_rsp_v, dm_rsp_v}, 0);
        chk("rst_rsp_data", {if_rsp_dat, dm_rsp_dat}, 0);
        chk("rst_rsp_err", {if_rsp_err, dm_rsp_err}, 0);
        rst_n = 1'b1;
        clear_inputs();
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_data;
    } txn_vec_t;

    // One isolated transaction: check acceptance, stable bus fields while waiting, one-cycle response.
    task automatic run_txn(input txn_vec_t v, input int idx);
        @(negedge clk);
        clear_inputs();
        if_v = !v.is_dm; if_addr = v.addr;
        dm_v = v.is_dm;  dm_addr = v.addr; dm_we = v.we; dm_wstrb = v.wstrb; dm_wdata = v.wdata;
        #1;
        chk($sformatf("t%0d_ready", idx), {if_rdy, dm_rdy}, v.is_dm ? 2'b01 : 2'b10);
        @(negedge clk);
        if_v = 1'b0; dm_v = 1'b0;
        for (int d = 0; d <= v.delay; d++) begin
            bus_ack   = (d == v.delay);
            bus_rdata = (d == v.delay) ? v.rdata : 32'h5A5A_5A5A;
            #1;
            chk($sformatf("t%0d_c%0d_bus_req", idx, d), bus_req, 1);
            chk($sformatf("t%0d_c%0d_bus_addr", idx, d), bus_addr, v.addr);
            chk($sformatf("t%0d_c%0d_bus_we", idx, d), bus_we, v.we);
            chk($sformatf("t%0d_c%0d_bus_wstrb", idx, d), bus_wstrb, v.exp_wstrb);
            if (v.we) chk($sformatf("t%0d_c%0d_bus_wdata", idx, d), bus_wdata, v.wdata);
            chk($sformatf("t%0d_c%0d_no_rsp", idx, d), {if_rsp_v, dm_rsp_v}, 0);
            @(negedge clk);
        end
        bus_ack = 1'b0;
        #1;
        chk($sformatf("t%0d_rsp_valid", idx), {if_rsp_v, dm_rsp_v}, v.is_dm ? 2'b01 : 2'b10);
        chk($sformatf("t%0d_rsp_data", idx), v.is_dm ? dm_rsp_dat : if_rsp_dat, v.exp_data);
        chk($sformatf("t%0d_rsp_err", idx), v.is_dm ? dm_rsp_err : if_rsp_err, 0);
        chk($sformatf("t%0d_bus_idle", idx), bus_req, 0);
        @(negedge clk);
        #1;
        chk($sformatf("t%0d_pulse_end", idx), {if_rsp_v, dm_rsp_v}, 0);
        chk($sformatf("t%0d_data_hold", idx), v.is_dm ? dm_rsp_dat : if_rsp_dat, v.exp_data);
    endtask

    // ---------------- random test: transaction-level reference model ----------------
    bit          if_pend, dm_pend, p_we;
    logic [31:0] p_if_addr, p_dm_addr, p_wdata;
    logic [3:0]  p_wstrb;
    bit          m_busy, m_is_dm, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          m_wait, streak;
    bit          e_if_v, e_dm_v, h_if_err, h_dm_err;
    logic [31:0] h_if_dat, h_dm_dat;

    task automatic model_reset();
        if_pend = 0; dm_pend = 0; m_busy = 0; m_wait = 0; streak = 0;
        e_if_v = 0; e_dm_v = 0; h_if_err = 0; h_dm_err = 0; h_if_dat = '0; h_dm_dat = '0;
    endtask

    task automatic model_respond(input bit err, input logic [31:0] rdata);
        logic [31:0] d;
        d = (err || m_we) ? 32'h0 : rdata;
        if (m_is_dm) begin e_dm_v = 1; h_dm_dat = d; h_dm_err = err; end
        else         begin e_if_v = 1; h_if_dat = d; h_if_err = err; end
        m_busy = 0;
    endtask

    task automatic rand_cycle(input int cyc);
        bit g_dm, g_if;
        @(negedge clk);
        if (!if_pend && $urandom_range(1, 0) == 1) begin if_pend = 1; p_if_addr = $urandom; end
        if (!dm_pend && $urandom_range(1, 0) == 1) begin
            dm_pend = 1; p_dm_addr = $urandom; p_we = $urandom_range(1, 0) == 1;
            p_wstrb = 4'($urandom_range(15, 0)); p_wdata = $urandom;
        end
        if_v = if_pend; if_addr = p_if_addr;
        dm_v = dm_pend; dm_addr = p_dm_addr; dm_we = p_we; dm_wstrb = p_wstrb; dm_wdata = p_wdata;
        bus_ack = ($urandom_range(2, 0) == 0); bus_rdata = $urandom;
        #1;
        g_dm = !m_busy && dm_pend && (streak < STARVE || !if_pend);
        g_if = !m_busy && if_pend && !g_dm;
        chk($sformatf("r%0d_ready", cyc), {if_rdy, dm_rdy}, {g_if, g_dm});
        chk($sformatf("r%0d_rsp_valid", cyc), {if_rsp_v, dm_rsp_v}, {e_if_v, e_dm_v});
        chk($sformatf("r%0d_if_data", cyc), if_rsp_dat, h_if_dat);
        chk($sformatf("r%0d_dm_data", cyc), dm_rsp_dat, h_dm_dat);
        chk($sformatf("r%0d_err", cyc), {if_rsp_err, dm_rsp_err}, {h_if_err, h_dm_err});
        chk($sformatf("r%0d_bus_req", cyc), bus_req, m_busy);
        if (m_busy) begin
            chk($sformatf("r%0d_bus_addr", cyc), bus_addr, m_addr);
            chk($sformatf("r%0d_bus_we", cyc), bus_we, m_we);
            chk($sformatf("r%0d_bus_wstrb", cyc), bus_wstrb, m_wstrb);
            if (m_we) chk($sformatf("r%0d_bus_wdata", cyc), bus_wdata, m_wdata);
        end
        // advance the model across the coming rising edge
        e_if_v = 0; e_dm_v = 0;
        if (m_busy) begin
            if (bus_ack) model_respond(0, bus_rdata);
            else begin
                m_wait++;
                if (TO_EN && m_wait == MAXW) model_respond(1, 32'h0);
            end
        end else begin
            if (!if_pend) streak = 0;
            if (g_dm) begin
                m_busy = 1; m_is_dm = 1; m_addr = p_dm_addr; m_we = p_we;
                m_wstrb = p_we ? p_wstrb : 4'h0; m_wdata = p_wdata; m_wait = 0;
                if (if_pend && streak < STARVE) streak++;
                dm_pend = 0;
            end else if (g_if) begin
                m_busy = 1; m_is_dm = 0; m_addr = p_if_addr; m_we = 0;
                m_wstrb = 4'h0; m_wdata = '0; m_wait = 0;
                streak = 0; if_pend = 0;
            end
        end
    endtask

    txn_vec_t vecs[5];
    bit       exp_seq[10];
    int       ng, hi, nrsp;

    initial begin
        vecs[0] = '{is_dm:0, we:0, addr:32'h0000_0100, wstrb:4'h0, wdata:32'h0, delay:0,
                    rdata:32'hDEAD_BEEF, exp_wstrb:4'h0, exp_data:32'hDEAD_BEEF};
        vecs[1] = '{is_dm:1, we:1, addr:32'h0000_2000, wstrb:4'h3, wdata:32'h0000_1234, delay:3,
                    rdata:32'hCAFE_F00D, exp_wstrb:4'h3, exp_data:32'h0};
        vecs[2] = '{is_dm:1, we:0, addr:32'h0000_3004, wstrb:4'hF, wdata:32'h55, delay:1,
                    rdata:32'h0BAD_F00D, exp_wstrb:4'h0, exp_data:32'h0BAD_F00D};
        vecs[3] = '{is_dm:0, we:0, addr:32'hFFFF_FFFC, wstrb:4'h0, wdata:32'h0, delay:5,
                    rdata:32'h0000_0013, exp_wstrb:4'h0, exp_data:32'h0000_0013};
        vecs[4] = '{is_dm:1, we:1, addr:32'h0000_0044, wstrb:4'hF, wdata:32'hFFFF_FFFF, delay:0,
                    rdata:32'h0000_AAAA, exp_wstrb:4'hF, exp_data:32'h0};
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        clear_inputs();
        rst_n = 1'b0;
        do_reset();

        for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

        // Both requesters asking continuously with immediate ack: four data grants per fetch grant.
        @(negedge clk);
        if_v = 1; if_addr = 32'h400; dm_v = 1; dm_addr = 32'h800; dm_we = 0;
        bus_ack = 1; bus_rdata = 32'h1111_2222;
        ng = 0;
        for (int c = 0; c < 24 && ng < 10; c++) begin
            #1;
            if (if_rdy && dm_rdy) chk("starve_both_ready", 1, 0);
            if (if_rdy || dm_rdy) begin
                chk($sformatf("starve_grant%0d_is_dm", ng), dm_rdy, exp_seq[ng]);
                ng++;
            end
            @(negedge clk);
        end
        chk("starve_grant_count", ng, 10);
        if_v = 0; dm_v = 0;
        @(negedge clk);
        bus_ack = 0;
        @(negedge clk);

        // Reset while a fetch waits on the bus: the late ack must produce nothing.
        @(negedge clk);
        if_v = 1; if_addr = 32'h500;
        #1;
        chk("rstmid_accept", if_rdy, 1);
        @(negedge clk);
        if_v = 0;
        #1;
        chk("rstmid_bus_req", bus_req, 1);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1; bus_ack = 1; bus_rdata = 32'h77;
        #1;
        chk("rstmid_bus_dropped", bus_req, 0);
        @(negedge clk);
        bus_ack = 0;
        #1;
        chk("rstmid_no_rsp", {if_rsp_v, dm_rsp_v}, 0);
        chk("rstmid_data_zero", if_rsp_dat, 0);
        run_txn(vecs[0], 10);

        // Long wait without ack.
        @(negedge clk);
        dm_v = 1; dm_addr = 32'h9000; dm_we = 0;
        #1;
        chk("to_accept", dm_rdy, 1);
        @(negedge clk);
        dm_v = 0;
        hi = 0; nrsp = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dm_rsp_v) break;
            if (bus_req) hi++;
            @(negedge clk);
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        chk("to_bus_req_cycles", hi, MAXW);
        chk("to_rsp_valid", dm_rsp_v, 1);
        chk("to_rsp_err", dm_rsp_err, 1);
        chk("to_rsp_data", dm_rsp_dat, 0);
        chk("to_bus_dropped", bus_req, 0);
        @(negedge clk);
        #1;
        chk("to_pulse_end", dm_rsp_v, 0);
        chk("to_err_hold", dm_rsp_err, 1);
        vecs[2].delay = MAXW - 1;
        run_txn(vecs[2], 20);
`else
        chk("nto_bus_req_cycles", hi, 40);
        chk("nto_no_rsp", dm_rsp_v, 0);
        bus_ack = 1; bus_rdata = 32'h600D_0001;
        @(negedge clk);
        bus_ack = 0;
        #1;
        chk("nto_rsp_valid", dm_rsp_v, 1);
        chk("nto_rsp_err", dm_rsp_err, 0);
        chk("nto_rsp_data", dm_rsp_dat, 32'h600D_0001);
`endif

        // Randomised traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) rand_cycle(c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
